// File: rtl/clint_bus_ctrl.sv
// Bus-side request/response controller for the CLINT timer block (msip, mtimecmp, mtime).
// Build option CLINT_BUS_CTRL_ATOMIC_CMP_EN: stage the mtimecmp LO half and commit both halves on the HI write.
module clint_bus_ctrl #(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] MSIP_OFF     = 16'h0000,
  parameter logic [ADDR_W-1:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [ADDR_W-1:0] MTIME_OFF    = 16'hBFF8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              msip_we_o,
  output logic              msip_wdata_o,
  output logic              mtimecmp_we_o,
  output logic [63:0]       mtimecmp_wdata_o,
  input  logic [63:0]       mtime_i
);

  localparam logic [ADDR_W-1:0] MTIMECMP_HI_OFF = MTIMECMP_OFF + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] MTIME_HI_OFF    = MTIME_OFF + ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              r_msip;
  logic [63:0]       r_cmp;
  logic [31:0]       r_mtime_hi;
  logic              r_latch_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
`ifdef CLINT_BUS_CTRL_ATOMIC_CMP_EN
  logic [31:0]       r_lo_stage;
`endif

  logic              w_misal;
  logic              w_hit_msip;
  logic              w_hit_cmp_lo;
  logic              w_hit_cmp_hi;
  logic              w_hit_mt_lo;
  logic              w_hit_mt_hi;
  logic              w_err;
  logic [31:0]       w_rdata;

  // Decode works on the registered request so EXEC sees a stable address.
  always_comb begin
    w_misal      = (r_addr[1:0] != 2'b00);
    w_hit_msip   = (r_addr == MSIP_OFF);
    w_hit_cmp_lo = (r_addr == MTIMECMP_OFF);
    w_hit_cmp_hi = (r_addr == MTIMECMP_HI_OFF);
    w_hit_mt_lo  = (r_addr == MTIME_OFF);
    w_hit_mt_hi  = (r_addr == MTIME_HI_OFF);
    w_err        = w_misal
                 | ~(w_hit_msip | w_hit_cmp_lo | w_hit_cmp_hi | w_hit_mt_lo | w_hit_mt_hi)
                 | (r_we & (w_hit_mt_lo | w_hit_mt_hi));
  end

  always_comb begin
    w_state_nxt      = r_state;
    req_ready_o      = 1'b0;
    rsp_valid_o      = 1'b0;
    msip_we_o        = 1'b0;
    msip_wdata_o     = 1'b0;
    mtimecmp_we_o    = 1'b0;
    mtimecmp_wdata_o = '0;
    w_rdata          = '0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
        if (!w_err) begin
          if (r_we) begin
            if (w_hit_msip) begin
              msip_we_o    = 1'b1;
              msip_wdata_o = r_wdata[0];
            end
`ifdef CLINT_BUS_CTRL_ATOMIC_CMP_EN
            if (w_hit_cmp_hi) begin
              mtimecmp_we_o    = 1'b1;
              mtimecmp_wdata_o = {r_wdata, r_lo_stage};
            end
`else
            if (w_hit_cmp_lo) begin
              mtimecmp_we_o    = 1'b1;
              mtimecmp_wdata_o = {r_cmp[63:32], r_wdata};
            end
            if (w_hit_cmp_hi) begin
              mtimecmp_we_o    = 1'b1;
              mtimecmp_wdata_o = {r_wdata, r_cmp[31:0]};
            end
`endif
          end else begin
            if (w_hit_msip)   w_rdata = {31'b0, r_msip};
            if (w_hit_cmp_lo) w_rdata = r_cmp[31:0];
            if (w_hit_cmp_hi) w_rdata = r_cmp[63:32];
            if (w_hit_mt_lo)  w_rdata = mtime_i[31:0];
            if (w_hit_mt_hi)  w_rdata = r_latch_valid ? r_mtime_hi : mtime_i[63:32];
          end
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && req_valid_i) begin
      r_we    <= req_we_i;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_msip        <= 1'b0;
      r_cmp         <= '0;
      r_mtime_hi    <= '0;
      r_latch_valid <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (msip_we_o)     r_msip <= msip_wdata_o;
      if (mtimecmp_we_o) r_cmp  <= mtimecmp_wdata_o;
      if (!w_err && !r_we) begin
        if (w_hit_mt_lo) begin
          r_mtime_hi    <= mtime_i[63:32];
          r_latch_valid <= 1'b1;
        end
        if (w_hit_mt_hi) r_latch_valid <= 1'b0;
      end
    end
  end

`ifdef CLINT_BUS_CTRL_ATOMIC_CMP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lo_stage <= '0;
    end else if (r_state == S_EXEC && !w_err && r_we && w_hit_cmp_lo) begin
      r_lo_stage <= r_wdata;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_rdata <= w_rdata;
      r_rsp_err   <= w_err;
    end else if (r_state == S_RESP && rsp_ready_i) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_clint_bus_ctrl.sv
// Scoreboard bench for clint_bus_ctrl; expectations follow CLINT_BUS_CTRL_ATOMIC_CMP_EN when defined.
module tb_clint_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        msip_we;
  logic        msip_wdata;
  logic        cmp_we;
  logic [63:0] cmp_wdata;
  logic [63:0] mtime;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  hold;
    logic [63:0] mtime;
  } req_t;

  // One observed transaction: response, strobe counts/values, latency, protocol flags.
  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [3:0]  n_msip;
    logic        msip_v;
    logic [3:0]  n_cmp;
    logic [63:0] cmp_v;
    logic [3:0]  lat;
    logic        ready_busy;
    logic        unstable;
    logic        tmo;
  } res_t;

  res_t exp_q[$];
  req_t stim_q[$];

  clint_bus_ctrl #(
    .ADDR_W      (16),
    .MSIP_OFF    (16'h0000),
    .MTIMECMP_OFF(16'h4000),
    .MTIME_OFF   (16'hBFF8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_err_o       (rsp_err),
    .msip_we_o       (msip_we),
    .msip_wdata_o    (msip_wdata),
    .mtimecmp_we_o   (cmp_we),
    .mtimecmp_wdata_o(cmp_wdata),
    .mtime_i         (mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic req_t mkq(logic we, logic [15:0] a, logic [31:0] d, int h, logic [63:0] mt);
    req_t q;
    q.we = we; q.addr = a; q.wdata = d; q.hold = 4'(h); q.mtime = mt;
    return q;
  endfunction

  function automatic res_t mkr(logic [31:0] rd, logic err, int nm, logic mv, int nc, logic [63:0] cv);
    res_t r;
    r = '0;
    r.rd = rd; r.err = err; r.n_msip = 4'(nm); r.msip_v = mv;
    r.n_cmp = 4'(nc); r.cmp_v = cv; r.lat = 4'd2;
    return r;
  endfunction

  task automatic bus_txn(input req_t q, output res_t r);
    int cyc;
    r = '0;
    mtime = q.mtime;
    @(negedge clk);
    req_valid = 1'b1; req_we = q.we; req_addr = q.addr; req_wdata = q.wdata; rsp_ready = 1'b0;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    if (req_ready !== 1'b1) begin
      r.tmo = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (msip_we === 1'b1) begin r.n_msip = r.n_msip + 4'd1; r.msip_v = msip_wdata; end
      if (cmp_we === 1'b1) begin r.n_cmp = r.n_cmp + 4'd1; r.cmp_v = cmp_wdata; end
      if (req_ready !== 1'b0) r.ready_busy = 1'b1;
    end while (rsp_valid !== 1'b1 && cyc < 16);
    r.lat = 4'(cyc);
    if (rsp_valid !== 1'b1) begin
      r.tmo = 1'b1;
      return;
    end
    r.rd = rsp_rdata; r.err = rsp_err;
    for (int i = 0; i < int'(q.hold); i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r.rd || rsp_err !== r.err) r.unstable = 1'b1;
      if (msip_we !== 1'b0 || cmp_we !== 1'b0) r.unstable = 1'b1;
      if (req_ready !== 1'b0) r.ready_busy = 1'b1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [101:0] got;
    logic [101:0] want;
    want = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mtime = '0;
    repeat (3) @(negedge clk);
    got = {req_ready, rsp_valid, rsp_rdata, rsp_err, msip_we, msip_wdata, cmp_we, cmp_wdata};
    n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_in: got %h want %h", got, want); end
    rst_n = 1'b1;
    @(negedge clk);
    got = {req_ready, rsp_valid, rsp_rdata, rsp_err, msip_we, msip_wdata, cmp_we, cmp_wdata};
    n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_out: got %h want %h", got, want); end
  endtask

  task automatic test_msip();
    res_t got, exp;
    req_t q;
    stim_q.push_back(mkq(1'b1, 16'h0000, 32'h0000_0001, 0, 64'h0)); exp_q.push_back(mkr(32'h0, 1'b0, 1, 1'b1, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h0000, 32'h0, 0, 64'h0));         exp_q.push_back(mkr(32'h1, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'h0000, 32'hFFFF_FFFE, 0, 64'h0)); exp_q.push_back(mkr(32'h0, 1'b0, 1, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h0000, 32'h0, 0, 64'h0));         exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      q = stim_q.pop_front();
      bus_txn(q, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL msip[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_mtimecmp();
    res_t got, exp;
    req_t q;
    stim_q.push_back(mkq(1'b1, 16'h4000, 32'h89AB_CDEF, 0, 64'h0));
`ifdef CLINT_BUS_CTRL_ATOMIC_CMP_EN
    exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h4000, 32'h0, 0, 64'h0));
    exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0));
`else
    exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 1, 64'h0000_0000_89AB_CDEF));
    stim_q.push_back(mkq(1'b0, 16'h4000, 32'h0, 0, 64'h0));
    exp_q.push_back(mkr(32'h89AB_CDEF, 1'b0, 0, 1'b0, 0, 64'h0));
`endif
    stim_q.push_back(mkq(1'b1, 16'h4004, 32'h0123_4567, 0, 64'h0));
    exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 1, 64'h0123_4567_89AB_CDEF));
    stim_q.push_back(mkq(1'b0, 16'h4000, 32'h0, 0, 64'h0)); exp_q.push_back(mkr(32'h89AB_CDEF, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h4004, 32'h0, 0, 64'h0)); exp_q.push_back(mkr(32'h0123_4567, 1'b0, 0, 1'b0, 0, 64'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      q = stim_q.pop_front();
      bus_txn(q, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL mtimecmp[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_mtime();
    res_t got, exp;
    req_t q;
    stim_q.push_back(mkq(1'b0, 16'hBFF8, 32'h0, 0, 64'h0000_0001_FFFF_FFFF)); exp_q.push_back(mkr(32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'hBFFC, 32'h0, 0, 64'h0000_0002_0000_0005)); exp_q.push_back(mkr(32'h0000_0001, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'hBFFC, 32'h0, 0, 64'h0000_0002_0000_0005)); exp_q.push_back(mkr(32'h0000_0002, 1'b0, 0, 1'b0, 0, 64'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      q = stim_q.pop_front();
      bus_txn(q, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL mtime[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_errors();
    res_t got, exp;
    req_t q;
    stim_q.push_back(mkq(1'b0, 16'hBFF8, 32'h0, 0, 64'h0000_0003_0000_0007)); exp_q.push_back(mkr(32'h0000_0007, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h0002, 32'h0, 5, 64'h0));                   exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h1000, 32'h0, 5, 64'h0));                   exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'hBFF8, 32'hDEAD_BEEF, 5, 64'h0));           exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'hBFFC, 32'hDEAD_BEEF, 0, 64'h0));           exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'h4001, 32'h5555_AAAA, 0, 64'h0));           exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'h0001, 32'h0000_0001, 0, 64'h0));           exp_q.push_back(mkr(32'h0, 1'b1, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h4000, 32'h0, 0, 64'h0));                   exp_q.push_back(mkr(32'h89AB_CDEF, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'hBFFC, 32'h0, 0, 64'h0000_0004_0000_0000)); exp_q.push_back(mkr(32'h0000_0003, 1'b0, 0, 1'b0, 0, 64'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      q = stim_q.pop_front();
      bus_txn(q, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL errors[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    req_t q;
    int   n_strobe;
    logic [2:0] flags;
    bus_txn(mkq(1'b1, 16'h4000, 32'h1111_1111, 0, 64'h0), got);
`ifdef CLINT_BUS_CTRL_ATOMIC_CMP_EN
    exp = mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0);
`else
    exp = mkr(32'h0, 1'b0, 0, 1'b0, 1, 64'h0123_4567_1111_1111);
`endif
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rstmid_lo: got %h want %h", got, exp); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4004; req_wdata = 32'h2222_2222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    n_strobe = 0;
    @(negedge clk);
    flags = {cmp_we, rsp_valid, req_ready};
    n_cmp++;
    if (flags !== 3'b001) begin n_bad++; $display("FAIL rstmid_exec: got %b want %b", flags, 3'b001); end
    repeat (2) begin
      @(negedge clk);
      if (cmp_we !== 1'b0 || msip_we !== 1'b0 || rsp_valid !== 1'b0) n_strobe++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (cmp_we !== 1'b0 || msip_we !== 1'b0 || rsp_valid !== 1'b0) n_strobe++;
    end
    n_cmp++;
    if (n_strobe !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d want 0", n_strobe); end
    stim_q.push_back(mkq(1'b0, 16'h4000, 32'h0, 0, 64'h0));         exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b0, 16'h4004, 32'h0, 0, 64'h0));         exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 0, 64'h0));
    stim_q.push_back(mkq(1'b1, 16'h4004, 32'hAAAA_5555, 0, 64'h0)); exp_q.push_back(mkr(32'h0, 1'b0, 0, 1'b0, 1, 64'hAAAA_5555_0000_0000));
    stim_q.push_back(mkq(1'b0, 16'hBFFC, 32'h0, 0, 64'h0000_0009_0000_0001)); exp_q.push_back(mkr(32'h0000_0009, 1'b0, 0, 1'b0, 0, 64'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      q = stim_q.pop_front();
      bus_txn(q, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL rstmid[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_msip();
    test_mtimecmp();
    test_mtime();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
